// File: rtl/mul_result_buffer_if.sv
// Handshake bundle between a signed multiplier stage, the result buffer and its consumer.
// The slave modport is the buffer side; the master modport is the producer/consumer side.
interface mul_result_buffer_if #(
  parameter int SIZE = 8
);
  logic                in_valid;
  logic                in_ready;
  logic [2*SIZE-1:0]   in_product;
  logic                in_overflow;
  logic                in_neg;
  logic                out_valid;
  logic                out_ready;
  logic [SIZE-1:0]     out_result;
  logic                out_overflow;
  logic                sticky_ovf;
  logic                clr_sticky;
  logic [1:0]          count;

  modport master (
    output in_valid, in_product, in_overflow, in_neg, out_ready, clr_sticky,
    input  in_ready, out_valid, out_result, out_overflow, sticky_ovf, count
  );

  modport slave (
    input  in_valid, in_product, in_overflow, in_neg, out_ready, clr_sticky,
    output in_ready, out_valid, out_result, out_overflow, sticky_ovf, count
  );
endinterface

// File: rtl/mul_result_buffer.sv
// Two-entry result FIFO that narrows 2*SIZE-bit signed products to SIZE bits with an overflow flag.
// Define MUL_RESULT_SATURATE_EN to saturate overflowing results instead of wrapping them.
module mul_result_buffer #(
  parameter int SIZE = 8
) (
  input logic               clk,
  input logic               rst,
  mul_result_buffer_if.slave bus
);
  logic [1:0]      r_count;
  logic [SIZE-1:0] r_res [2];
  logic            r_ovf [2];
  logic            r_sticky;

  logic            w_in_ready;
  logic            w_out_valid;
  logic            w_push;
  logic            w_pop;
  logic [SIZE:0]   w_top;
  logic            w_fits;
  logic            w_new_ovf;
  logic [SIZE-1:0] w_new_res;

  assign w_in_ready  = (r_count != 2'd2);
  assign w_out_valid = (r_count != 2'd0);
  assign w_push      = bus.in_valid && w_in_ready;
  assign w_pop       = w_out_valid && bus.out_ready;

  // The product fits in SIZE signed bits only if its upper SIZE+1 bits are a pure sign extension.
  assign w_top     = bus.in_product[2*SIZE-1:SIZE-1];
  assign w_fits    = (w_top == '0) || (w_top == '1);
  assign w_new_ovf = bus.in_overflow || !w_fits;

`ifdef MUL_RESULT_SATURATE_EN
  always_comb begin
    w_new_res = bus.in_product[SIZE-1:0];
    if (w_new_ovf) begin
      w_new_res = bus.in_neg ? {1'b1, {(SIZE-1){1'b0}}} : {1'b0, {(SIZE-1){1'b1}}};
    end
  end
`else
  logic w_unused_neg;
  assign w_unused_neg = bus.in_neg;
  assign w_new_res    = bus.in_product[SIZE-1:0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count  <= 2'd0;
      r_res    <= '{default: '0};
      r_ovf    <= '{default: 1'b0};
      r_sticky <= 1'b0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) begin
            r_res[0] <= w_new_res;
            r_ovf[0] <= w_new_ovf;
          end else begin
            r_res[1] <= w_new_res;
            r_ovf[1] <= w_new_ovf;
          end
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_res[0] <= r_res[1];
          r_ovf[0] <= r_ovf[1];
          r_count  <= r_count - 2'd1;
        end
        // Push and pop together can only happen at count 1: the new entry replaces the head.
        2'b11: begin
          r_res[0] <= w_new_res;
          r_ovf[0] <= w_new_ovf;
        end
        default: ;
      endcase

      if (w_push && w_new_ovf) begin
        r_sticky <= 1'b1;
      end else if (bus.clr_sticky) begin
        r_sticky <= 1'b0;
      end
    end
  end

  // Outputs derive from the count so an asynchronous reset shows up immediately.
  assign bus.in_ready     = w_in_ready;
  assign bus.out_valid    = w_out_valid;
  assign bus.out_result   = w_out_valid ? r_res[0] : '0;
  assign bus.out_overflow = w_out_valid ? r_ovf[0] : 1'b0;
  assign bus.sticky_ovf   = r_sticky;
  assign bus.count        = r_count;
endmodule

// File: tb/tb_mul_result_buffer.sv
// Scoreboard bench for mul_result_buffer: directed corner cases followed by random traffic.
module tb_mul_result_buffer;
  localparam int SIZE = 8;

  typedef struct {
    logic [SIZE-1:0] res;
    logic            ovf;
  } ent_t;

  logic clk;
  logic rst;
  mul_result_buffer_if #(.SIZE(SIZE)) bus ();

  mul_result_buffer #(.SIZE(SIZE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ent_t exp_q[$];
  bit   exp_sticky;
  bit   pop_pending;
  int   checks;
  int   errors;

  // Reference narrowing: range test on the signed product value.
  function automatic ent_t ref_entry(logic [2*SIZE-1:0] p, bit io, bit ng);
    ent_t e;
    int   sp;
    sp    = int'($signed(p));
    e.ovf = io || (sp > 127) || (sp < -128);
    e.res = p[SIZE-1:0];
`ifdef MUL_RESULT_SATURATE_EN
    if (e.ovf) e.res = ng ? 8'h80 : 8'h7F;
`else
    if (ng) e.res = p[SIZE-1:0];
`endif
    return e;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  // Monitor: compare visible DUT state with the model half a cycle after each edge.
  always @(negedge clk) begin
    if (!rst) begin
      chk("count", 16'(bus.count), 16'(exp_q.size()));
      chk("in_ready", 16'(bus.in_ready), 16'(exp_q.size() < 2));
      chk("out_valid", 16'(bus.out_valid), 16'(exp_q.size() != 0));
      chk("sticky_ovf", 16'(bus.sticky_ovf), 16'(exp_sticky));
      if (exp_q.size() == 0) begin
        chk("empty_result", 16'(bus.out_result), 16'h0);
        chk("empty_ovf", 16'(bus.out_overflow), 16'h0);
        pop_pending = 1'b0;
      end else begin
        chk("head_result", 16'(bus.out_result), 16'(exp_q[0].res));
        chk("head_ovf", 16'(bus.out_overflow), 16'(exp_q[0].ovf));
        if (bus.out_ready) $display("POP res=%h ovf=%0d", bus.out_result, bus.out_overflow);
        pop_pending = bus.out_ready;
      end
    end
  end

  always @(posedge clk) begin
    if (!rst && pop_pending) void'(exp_q.pop_front());
    pop_pending = 1'b0;
  end

  // One cycle of stimulus, starting and ending 1 time unit after a rising edge.
  task automatic drive(input bit v, input logic [15:0] p, input bit io, input bit ng,
                       input bit ordy, input bit clr);
    bit   acc;
    ent_t e;
    bus.in_valid    = v;
    bus.in_product  = p;
    bus.in_overflow = io;
    bus.in_neg      = ng;
    bus.out_ready   = ordy;
    bus.clr_sticky  = clr;
    @(negedge clk);
    acc = v && bus.in_ready;
    e   = ref_entry(p, io, ng);
    @(posedge clk);
    if (acc) begin
      exp_q.push_back(e);
      $display("PUSH p=%h io=%0d neg=%0d -> res=%h ovf=%0d", p, io, ng, e.res, e.ovf);
    end
    if (acc && e.ovf) exp_sticky = 1'b1;
    else if (clr)     exp_sticky = 1'b0;
    #1;
  endtask

  task automatic idle(input bit ordy);
    drive(1'b0, 16'(SIZE'($urandom)), 1'b1, 1'b1, ordy, 1'b0);
  endtask

  task automatic check_reset_outputs();
    chk("rst_count", 16'(bus.count), 16'h0);
    chk("rst_out_valid", 16'(bus.out_valid), 16'h0);
    chk("rst_out_result", 16'(bus.out_result), 16'h0);
    chk("rst_out_ovf", 16'(bus.out_overflow), 16'h0);
    chk("rst_sticky", 16'(bus.sticky_ovf), 16'h0);
    chk("rst_in_ready", 16'(bus.in_ready), 16'h1);
  endtask

  initial begin
    logic [15:0] p;
    int          s;
    checks = 0; errors = 0; exp_sticky = 0; pop_pending = 0;
    bus.in_valid = 0; bus.in_product = '0; bus.in_overflow = 0; bus.in_neg = 0;
    bus.out_ready = 0; bus.clr_sticky = 0;
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs();
    rst = 1'b0;

    // Simple push, then overflow push (0x0190 = 400).
    drive(1, 16'h0014, 0, 0, 0, 0);
    drive(1, 16'h0190, 0, 0, 0, 0);
    idle(1); idle(1); idle(0);
    // Fill to two, third rejected, then drain in order.
    drive(1, 16'h0011, 0, 0, 0, 0);
    drive(1, 16'hFFEE, 0, 1, 0, 0);
    drive(1, 16'h0033, 0, 0, 0, 0);
    idle(1); idle(1); idle(0);
    // Push+pop at count 1.
    drive(1, 16'h0005, 0, 0, 0, 0);
    drive(1, 16'hFF80, 0, 1, 1, 0);
    drive(1, 16'hFF7F, 0, 1, 1, 0);
    idle(1); idle(0);
    // Clear versus same-cycle set, then clear alone; pop at empty ignored.
    drive(1, 16'h0001, 1, 1, 1, 1);
    drive(0, 16'h0000, 0, 0, 1, 1);
    idle(1);
    // Reset between edges with count = 2.
    drive(1, 16'h8000, 0, 1, 0, 0);
    drive(1, 16'h007F, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    check_reset_outputs();
    exp_q.delete();
    exp_sticky = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    drive(1, 16'h0042, 0, 0, 0, 0);
    idle(1);

    // Random traffic: mix of in-range and arbitrary products.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) p = 16'($urandom);
      else begin
        s = int'($urandom_range(0, 255)) - 128;
        p = 16'(s);
      end
      drive($urandom_range(0, 1) == 1, p, $urandom_range(0, 7) == 0,
            $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0,
            $urandom_range(0, 5) == 0);
    end
    for (int i = 0; i < 3; i++) idle(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
